gpu_cmd_queue: RTL and testbench

GPU_CMD_QUEUE -- requirements
Module: gpu_cmd_queue

---
 rtl/gpu_pkg.sv | 31 +++
 rtl/gpu_cmd_fifo.sv | 61 ++++++
 rtl/gpu_cmd_queue.sv | 128 ++++++++++++
 tb/tb_gpu_cmd_queue.sv | 326 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gpu_pkg.sv
// rtl/gpu_pkg.sv - shared GPU command constants, field positions and issue FSM states
package gpu_pkg;

  localparam logic [3:0] GPU_OP_READ = 4'b0000;
  localparam logic [3:0] GPU_OP_LOAD = 4'b0001;
  localparam logic [3:0] GPU_OP_EXEC = 4'b0010;

  localparam int GPU_OP_LSB  = 10;
  localparam int GPU_OP_MSB  = 13;
  localparam int GPU_LANE_W  = 16;
  localparam int GPU_CMD_W   = 32;
  localparam int GPU_DATA_W  = 4 * GPU_LANE_W;
  localparam int GPU_ENTRY_W = GPU_CMD_W + GPU_DATA_W;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    GAP
  } issue_state_t;

  // Opcode field of a host command word
  function automatic logic [3:0] gpu_opcode(input logic [GPU_CMD_W-1:0] cmd);
    return cmd[GPU_OP_MSB:GPU_OP_LSB];
  endfunction

  // Read commands return data and therefore need a free result register
  function automatic logic gpu_is_read(input logic [GPU_CMD_W-1:0] cmd);
    return gpu_opcode(cmd) == GPU_OP_READ;
  endfunction

endpackage

// File: rtl/gpu_cmd_fifo.sv
// rtl/gpu_cmd_fifo.sv - command FIFO storage with wrap-around pointers and occupancy count
module gpu_cmd_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 96
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_wr;
  logic             do_rd;

  // A full FIFO refuses writes even when a read frees a slot in the same cycle
  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign do_wr   = wr_en && !full;
  assign do_rd   = rd_en && !empty;
  assign rd_data = mem[rd_ptr];

  // Storage is deliberately left unreset; only pointers and count define validity
  always_ff @(posedge clk) begin
    if (do_wr) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_rd) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({do_wr, do_rd})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/gpu_cmd_queue.sv
// rtl/gpu_cmd_queue.sv - host command queue issuing strobed requests to gpu_core
import gpu_pkg::*;

module gpu_cmd_queue #(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] in_cmd,
  input  logic [63:0] in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [31:0] command,
  output logic [63:0] data_in,
  output logic        stb,
  input  logic        ack,
  input  logic [63:0] data_out,
  output logic [63:0] res_data,
  output logic        res_valid,
  input  logic        res_ready,
  output logic        err,
  input  logic        err_clr
);

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TCNT_LAST = TW'(TIMEOUT - 1);

  issue_state_t           state;
  logic [TW-1:0]          tcnt;
  logic [GPU_ENTRY_W-1:0] head;
  logic [GPU_CMD_W-1:0]   head_cmd;
  logic [GPU_DATA_W-1:0]  head_data;
  logic                   fifo_full;
  logic                   fifo_empty;
  logic                   issue_ok;
  logic                   timeout_hit;
  logic                   pop;
  logic                   read_ack;

  assign head_cmd  = head[GPU_ENTRY_W-1:GPU_DATA_W];
  assign head_data = head[GPU_DATA_W-1:0];
  assign in_ready  = !fifo_full;

  // A read at the head waits for the host to take the previous result
  assign issue_ok    = !fifo_empty && !(gpu_is_read(head_cmd) && res_valid);
  assign timeout_hit = (state == ISSUE) && !ack && (tcnt == TCNT_LAST);
  assign pop         = (state == ISSUE) && (ack || timeout_hit);
  assign read_ack    = (state == ISSUE) && ack && gpu_is_read(command);

  gpu_cmd_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (GPU_ENTRY_W)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (in_valid),
    .wr_data ({in_cmd, in_data}),
    .rd_en   (pop),
    .rd_data (head),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  // Issue FSM: present the head, hold it until ack or timeout, then one stb-low gap
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      stb     <= 1'b0;
      command <= '0;
      data_in <= '0;
      tcnt    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (issue_ok) begin
            command <= head_cmd;
            data_in <= head_data;
            stb     <= 1'b1;
            tcnt    <= '0;
            state   <= ISSUE;
          end
        end
        ISSUE: begin
          if (ack || timeout_hit) begin
            stb   <= 1'b0;
            tcnt  <= '0;
            state <= GAP;
          end else begin
            tcnt <= tcnt + 1'b1;
          end
        end
        GAP: begin
          state <= IDLE;
        end
        default: begin
          stb   <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

  // Result register: a new read ack wins over the host taking the old result
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_valid <= 1'b0;
      res_data  <= '0;
    end else if (read_ack) begin
      res_valid <= 1'b1;
      res_data  <= data_out;
    end else if (res_valid && res_ready) begin
      res_valid <= 1'b0;
    end
  end

  // Sticky timeout flag: a timeout in the clearing cycle keeps it set
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err <= 1'b0;
    end else if (timeout_hit) begin
      err <= 1'b1;
    end else if (err_clr) begin
      err <= 1'b0;
    end
  end

endmodule

// File: tb/tb_gpu_cmd_queue.sv
// tb/tb_gpu_cmd_queue.sv - randomized and directed bench for gpu_cmd_queue against a queue model
module tb_gpu_cmd_queue;

  localparam int DEPTH   = 4;
  localparam int TIMEOUT = 255;

  logic        clk;
  logic        rst_n;
  logic [31:0] in_cmd;
  logic [63:0] in_data;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] command;
  logic [63:0] data_in;
  logic        stb;
  logic        ack;
  logic [63:0] data_out;
  logic [63:0] res_data;
  logic        res_valid;
  logic        res_ready;
  logic        err;
  logic        err_clr;

  int errors = 0;
  int checks = 0;

  gpu_cmd_queue #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_cmd    (in_cmd),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .command   (command),
    .data_in   (data_in),
    .stb       (stb),
    .ack       (ack),
    .data_out  (data_out),
    .res_data  (res_data),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .err       (err),
    .err_clr   (err_clr)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: ordered list of queued commands plus the visible host/core state
  typedef struct packed {
    logic [31:0] c;
    logic [63:0] d;
  } ent_t;

  ent_t        mq[$];
  logic        m_stb;
  logic [31:0] m_cmd;
  logic [63:0] m_data;
  logic        m_res_valid;
  logic [63:0] m_res_data;
  logic        m_err;
  int          hi_cnt;
  int          low_run;
  int          last_hi_len;

  // Compare on every falling edge, then advance the model by the coming rising edge
  always @(negedge clk) begin : mon
    logic do_push, do_pop, tmo, rd_ack, issuable;
    ent_t e;
    if (!rst_n) begin
      mq.delete();
      m_stb = 1'b0; m_cmd = '0; m_data = '0;
      m_res_valid = 1'b0; m_res_data = '0; m_err = 1'b0;
      hi_cnt = 0; low_run = 1; last_hi_len = 0;
    end else begin
      chk("in_ready", in_ready, (mq.size() != DEPTH));
      chk("stb", stb, m_stb);
      chk("command", command, m_cmd);
      chk("data_in", data_in, m_data);
      chk("res_valid", res_valid, m_res_valid);
      if (m_res_valid) chk("res_data", res_data, m_res_data);
      chk("err", err, m_err);

      do_push  = in_valid && (mq.size() != DEPTH);
      do_pop   = 1'b0;
      tmo      = 1'b0;
      rd_ack   = 1'b0;
      issuable = (mq.size() > 0) && !((mq[0].c[13:10] == 4'd0) && m_res_valid);
      if (m_stb) begin
        hi_cnt++;
        if (ack) begin
          do_pop = 1'b1;
          rd_ack = (m_cmd[13:10] == 4'd0);
        end else if (hi_cnt == TIMEOUT) begin
          do_pop = 1'b1;
          tmo    = 1'b1;
        end
        if (do_pop) begin
          last_hi_len = hi_cnt;
          m_stb       = 1'b0;
          low_run     = 0;
        end
      end else begin
        low_run++;
        if (issuable && low_run >= 2) begin
          m_stb  = 1'b1;
          m_cmd  = mq[0].c;
          m_data = mq[0].d;
          hi_cnt = 0;
        end
      end
      if (rd_ack) begin
        m_res_valid = 1'b1;
        m_res_data  = data_out;
      end else if (m_res_valid && res_ready) begin
        m_res_valid = 1'b0;
      end
      if (tmo) m_err = 1'b1;
      else if (err_clr) m_err = 1'b0;
      if (do_pop) void'(mq.pop_front());
      if (do_push) begin
        e.c = in_cmd;
        e.d = in_data;
        mq.push_back(e);
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 after the edge that accepted the entry
  task automatic push(input logic [31:0] c, input logic [63:0] d);
    in_cmd   = c;
    in_data  = d;
    in_valid = 1'b1;
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      if (in_ready) begin
        @(posedge clk); #1;
        in_valid = 1'b0;
        return;
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    checks++; errors++;
    $display("FAIL push_timeout: cmd %h never accepted", c);
  endtask

  // Returns at the falling edge where stb first shows the wanted level
  task automatic wait_stb(input logic lvl, input int bound);
    for (int i = 0; i < bound; i++) begin
      @(negedge clk);
      if (stb === lvl) return;
    end
    checks++; errors++;
    $display("FAIL wait_stb: stb did not reach %0b within %0d cycles", lvl, bound);
  endtask

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
    end
  endtask

  initial begin
    rst_n = 1'b0; in_cmd = '0; in_data = '0; in_valid = 1'b0;
    ack = 1'b0; data_out = '0; res_ready = 1'b0; err_clr = 1'b0;
    cycles(3);
    rst_n = 1'b1;

    // Reset state
    @(negedge clk); #1;
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_stb", stb, 1'b0);
    chk("rst_res_valid", res_valid, 1'b0);
    chk("rst_err", err, 1'b0);
    @(posedge clk); #1;

    // Burst push with ack held low: FIFO fills after four entries
    for (int i = 0; i < 4; i++)
      push(32'h0000_0400 + 32'(i * 32'h20), 64'h3000_2000_1000_0000 + 64'(i));
    @(negedge clk); #1;
    chk("burst_full", in_ready, 1'b0);
    chk("burst_head_cmd", command, 32'h0000_0400);
    chk("burst_head_data", data_in, 64'h3000_2000_1000_0000);
    @(posedge clk); #1;
    ack = 1'b1;
    push(32'h0000_0480, 64'h3000_2000_1000_0004);
    cycles(20);
    ack = 1'b0;
    @(negedge clk); #1;
    chk("burst_drained", in_ready, 1'b1);
    @(posedge clk); #1;

    // Single issue, ack two cycles after stb rises
    push(32'h0000_0400, 64'h7000_6000_5000_4000);
    wait_stb(1'b1, 10);
    @(posedge clk); #1;
    @(posedge clk); #1;
    ack = 1'b1;
    @(posedge clk); #1;
    ack = 1'b0;
    @(negedge clk); #1;
    chk("single_hi_len", last_hi_len, 3);
    chk("single_gap_stb", stb, 1'b0);
    @(posedge clk); #1;

    // Read result, then a second read held off until the result is taken
    push(32'h0000_0080, 64'h1);
    wait_stb(1'b1, 10);
    @(posedge clk); #1;
    ack = 1'b1; data_out = 64'h0011_0022_0033_0044;
    @(posedge clk); #1;
    ack = 1'b0; data_out = '0;
    @(negedge clk); #1;
    chk("read_res_valid", res_valid, 1'b1);
    chk("read_res_data", res_data, 64'h0011_0022_0033_0044);
    @(posedge clk); #1;
    push(32'h0000_0080, 64'h2);
    cycles(10);
    @(negedge clk); #1;
    chk("read_stalled_stb", stb, 1'b0);
    @(posedge clk); #1;
    res_ready = 1'b1;
    @(posedge clk); #1;
    res_ready = 1'b0;
    wait_stb(1'b1, 10);
    @(posedge clk); #1;
    ack = 1'b1; data_out = 64'hAAAA_BBBB_CCCC_DDDD;
    @(posedge clk); #1;
    ack = 1'b0;
    @(negedge clk); #1;
    chk("read2_res_data", res_data, 64'hAAAA_BBBB_CCCC_DDDD);
    @(posedge clk); #1;
    res_ready = 1'b1;
    cycles(2);
    res_ready = 1'b0;

    // Timeout: the head is dropped after TIMEOUT strobe cycles and the next one issues
    push(32'h0000_0400, 64'h10);
    push(32'h0000_0800, 64'h20);
    wait_stb(1'b1, 10);
    wait_stb(1'b0, 300);
    #1;
    chk("timeout_hi_len", last_hi_len, 255);
    chk("timeout_err", err, 1'b1);
    wait_stb(1'b1, 5);
    #1;
    chk("timeout_next_cmd", command, 32'h0000_0800);
    @(posedge clk); #1;
    ack = 1'b1;
    @(posedge clk); #1;
    ack = 1'b0; err_clr = 1'b1;
    @(posedge clk); #1;
    err_clr = 1'b0;
    @(negedge clk); #1;
    chk("err_cleared", err, 1'b0);
    @(posedge clk); #1;

    // Ten push/ack pairs walk the pointers around the ring
    for (int i = 0; i < 10; i++) begin
      push(32'h0000_0800 | 32'(i), 64'(i) << 16);
      wait_stb(1'b1, 10);
      @(posedge clk); #1;
      ack = 1'b1;
      @(posedge clk); #1;
      ack = 1'b0;
    end
    cycles(3);

    // Random traffic
    for (int n = 0; n < 2500; n++) begin
      int pick;
      pick     = int'($urandom_range(0, 3));
      in_cmd   = $urandom;
      in_cmd[13:10] = (pick < 3) ? 4'(pick) : 4'($urandom_range(3, 15));
      in_data  = {$urandom, $urandom};
      in_valid = ($urandom_range(0, 99) < 50);
      ack      = ($urandom_range(0, 99) < 40);
      data_out = {$urandom, $urandom};
      res_ready = ($urandom_range(0, 99) < 50);
      err_clr  = ($urandom_range(0, 99) < 5);
      @(posedge clk); #1;
    end
    in_valid = 1'b0; ack = 1'b1; res_ready = 1'b1; err_clr = 1'b0;
    cycles(40);
    ack = 1'b0; res_ready = 1'b0;

    // Reset in the middle of an issue drops stb at once and empties the queue
    push(32'h0000_0400, 64'h1);
    push(32'h0000_0420, 64'h2);
    push(32'h0000_0440, 64'h3);
    wait_stb(1'b1, 10);
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk("rst_mid_stb", stb, 1'b0);
    chk("rst_mid_in_ready", in_ready, 1'b1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    cycles(5);
    @(negedge clk); #1;
    chk("rst_after_stb", stb, 1'b0);
    chk("rst_after_command", command, 32'h0);
    @(posedge clk); #1;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
